// File: rtl/core_pkg.sv
// Shared core-control types: stage sequencer state encoding and counter width default.
package core_pkg;

    localparam int unsigned INSTRET_W_DEFAULT = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_WB    = 3'd4,
        ST_TRAP  = 3'd5,
        ST_HALT  = 3'd6
    } ctrl_state_e;

endpackage

// File: rtl/core_ctrl_counter.sv
// Free-running event counter with synchronous clear; wraps modulo 2^W.
module core_ctrl_counter #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/core_stage_ctrl.sv
// Multi-cycle stage sequencer: FETCH, EXEC, optional MEM, WB, with trap/halt steering
// and a retired-instruction counter. All strobes are Moore outputs of the state register.
module core_stage_ctrl
    import core_pkg::*;
#(
    parameter int unsigned INSTRET_W = INSTRET_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 fetch_stage_valid,
    input  logic                 fetch_stage_ready,
    output logic                 exec_stage_valid,
    input  logic                 exec_is_mem,
    input  logic                 exec_trap,
    output logic                 mem_stage_valid,
    input  logic                 mem_stage_ready,
    input  logic                 mem_fault,
    output logic                 wb_stage_valid,
    output logic                 pc_commit,
    output logic                 trap_valid,
    input  logic                 irq_pending,
    input  logic                 halt_req,
    output logic                 halted,
    output logic [INSTRET_W-1:0] instret
);

    ctrl_state_e state, state_nxt;
    logic        retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // halt_req is only honoured on a transition into FETCH, so a handshake in progress is never cut short
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  state_nxt = halt_req ? ST_HALT : ST_FETCH;
            ST_FETCH: if (fetch_stage_ready) state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (exec_trap)        state_nxt = ST_TRAP;
                else if (exec_is_mem) state_nxt = ST_MEM;
                else                  state_nxt = ST_WB;
            end
            ST_MEM:   if (mem_stage_ready) state_nxt = mem_fault ? ST_TRAP : ST_WB;
            ST_WB: begin
                if (irq_pending)   state_nxt = ST_TRAP;
                else if (halt_req) state_nxt = ST_HALT;
                else               state_nxt = ST_FETCH;
            end
            ST_TRAP:  state_nxt = halt_req ? ST_HALT : ST_FETCH;
            ST_HALT:  if (!halt_req) state_nxt = ST_FETCH;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        fetch_stage_valid = 1'b0;
        exec_stage_valid  = 1'b0;
        mem_stage_valid   = 1'b0;
        wb_stage_valid    = 1'b0;
        pc_commit         = 1'b0;
        trap_valid        = 1'b0;
        halted            = 1'b0;
        retire            = 1'b0;
        unique case (state)
            ST_FETCH: fetch_stage_valid = 1'b1;
            ST_EXEC:  exec_stage_valid  = 1'b1;
            ST_MEM:   mem_stage_valid   = 1'b1;
            ST_WB: begin
                wb_stage_valid = 1'b1;
                pc_commit      = 1'b1;
                retire         = 1'b1;
            end
            ST_TRAP: begin
                trap_valid = 1'b1;
                pc_commit  = 1'b1;
            end
            ST_HALT:  halted = 1'b1;
            default:  ;
        endcase
    end

    core_ctrl_counter #(
        .W(INSTRET_W)
    ) u_instret (
        .clk  (clk),
        .rst  (rst),
        .inc  (retire),
        .count(instret)
    );

endmodule

// File: tb/tb_core_stage_ctrl.sv
// Self-checking bench for core_stage_ctrl: per-instruction expected output traces are
// generated from the stage rules and replayed cycle by cycle against the DUT.
module tb_core_stage_ctrl;

    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_F    = 7'b1000000;
    localparam logic [6:0] O_E    = 7'b0100000;
    localparam logic [6:0] O_M    = 7'b0010000;
    localparam logic [6:0] O_W    = 7'b0001100;
    localparam logic [6:0] O_T    = 7'b0000110;
    localparam logic [6:0] O_H    = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_stage_ready, exec_is_mem, exec_trap, mem_stage_ready, mem_fault;
    logic        irq_pending, halt_req;
    logic        fetch_stage_valid, exec_stage_valid, mem_stage_valid, wb_stage_valid;
    logic        pc_commit, trap_valid, halted;
    logic [63:0] instret;
    logic        n_fv, n_ev, n_mv, n_wv, n_pc, n_tv, n_h;
    logic [2:0]  instret_n;

    always #5 clk = ~clk;

    core_stage_ctrl #(.INSTRET_W(64)) dut (
        .clk(clk), .rst(rst),
        .fetch_stage_valid(fetch_stage_valid), .fetch_stage_ready(fetch_stage_ready),
        .exec_stage_valid(exec_stage_valid), .exec_is_mem(exec_is_mem), .exec_trap(exec_trap),
        .mem_stage_valid(mem_stage_valid), .mem_stage_ready(mem_stage_ready), .mem_fault(mem_fault),
        .wb_stage_valid(wb_stage_valid), .pc_commit(pc_commit), .trap_valid(trap_valid),
        .irq_pending(irq_pending), .halt_req(halt_req), .halted(halted), .instret(instret)
    );

    // Narrow counter instance shares the stimulus so wrap-around is reached in a short run.
    core_stage_ctrl #(.INSTRET_W(3)) dut_n (
        .clk(clk), .rst(rst),
        .fetch_stage_valid(n_fv), .fetch_stage_ready(fetch_stage_ready),
        .exec_stage_valid(n_ev), .exec_is_mem(exec_is_mem), .exec_trap(exec_trap),
        .mem_stage_valid(n_mv), .mem_stage_ready(mem_stage_ready), .mem_fault(mem_fault),
        .wb_stage_valid(n_wv), .pc_commit(n_pc), .trap_valid(n_tv),
        .irq_pending(irq_pending), .halt_req(halt_req), .halted(n_h), .instret(instret_n)
    );

    typedef struct {
        logic            fr, mr, mf, im, tr, irq, hl;
        logic [6:0]      exp;
        longint unsigned n;
    } step_t;

    step_t           q[$];
    logic [6:0]      act_o[$];
    logic [63:0]     act_n[$];
    logic [2:0]      act_n3[$];
    longint unsigned model_cnt;
    int unsigned     n_tests = 0;
    int unsigned     n_fail  = 0;

    function automatic logic [6:0] outs();
        return {fetch_stage_valid, exec_stage_valid, mem_stage_valid, wb_stage_valid,
                pc_commit, trap_valid, halted};
    endfunction

    // Inputs the current state must ignore are randomised.
    function automatic step_t junk(input logic [6:0] e);
        step_t s;
        s.fr  = 1'($urandom_range(0, 1));
        s.mr  = 1'($urandom_range(0, 1));
        s.mf  = 1'($urandom_range(0, 1));
        s.im  = 1'($urandom_range(0, 1));
        s.tr  = 1'($urandom_range(0, 1));
        s.irq = 1'($urandom_range(0, 1));
        s.hl  = 1'($urandom_range(0, 1));
        s.exp = e;
        s.n   = model_cnt;
        return s;
    endfunction

    // Expected trace of one instruction starting in its first FETCH cycle.
    function automatic void gen_instr(input int unsigned fw, input bit m, input bit t,
                                      input int unsigned mw, input bit f, input bit irq,
                                      input bit h, input int unsigned hc);
        step_t s;
        bit    to_trap;
        for (int unsigned i = 0; i <= fw; i++) begin
            s = junk(O_F); s.fr = (i == fw); q.push_back(s);
        end
        s = junk(O_E); s.tr = t; s.im = m; q.push_back(s);
        to_trap = t;
        if (!t && m) begin
            for (int unsigned i = 0; i <= mw; i++) begin
                s = junk(O_M); s.mr = (i == mw);
                if (i == mw) s.mf = f;
                q.push_back(s);
            end
            to_trap = f;
        end
        if (!to_trap) begin
            s = junk(O_W); s.irq = irq; s.hl = h; q.push_back(s);
            model_cnt++;
            to_trap = irq;
        end
        if (to_trap) begin
            s = junk(O_T); s.hl = h; q.push_back(s);
        end
        if (h) begin
            for (int unsigned i = 0; i < hc; i++) begin
                s = junk(O_H); s.hl = 1'b1; q.push_back(s);
            end
            s = junk(O_H); s.hl = 1'b0; q.push_back(s);
        end
    endfunction

    task automatic play();
        act_o.delete(); act_n.delete(); act_n3.delete();
        foreach (q[i]) begin
            act_o.push_back(outs());
            act_n.push_back(instret);
            act_n3.push_back(instret_n);
            fetch_stage_ready = q[i].fr; mem_stage_ready = q[i].mr; mem_fault = q[i].mf;
            exec_is_mem = q[i].im; exec_trap = q[i].tr; irq_pending = q[i].irq; halt_req = q[i].hl;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fetch_stage_ready = 0; mem_stage_ready = 0; mem_fault = 0;
        exec_is_mem = 0; exec_trap = 0; irq_pending = 0; halt_req = 0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (outs() !== O_NONE) begin
            n_fail++; $display("FAIL reset_outputs: got %b want %b", outs(), O_NONE);
        end
        n_tests++;
        if (instret !== 64'd0 || instret_n !== 3'd0) begin
            n_fail++; $display("FAIL reset_instret: got %0d/%0d want 0/0", instret, instret_n);
        end
        rst = 1'b0;
        model_cnt = 0;
        @(negedge clk);
    endtask

    task automatic test_alu_stream();
        q.delete();
        for (int unsigned k = 0; k < 4; k++) gen_instr(0, 0, 0, 0, 0, 0, 0, 0);
        play();
        foreach (q[i]) begin
            n_tests++;
            if (act_o[i] !== q[i].exp || act_n[i] !== q[i].n) begin
                n_fail++;
                $display("FAIL alu_stream[%0d]: got %b/%0d want %b/%0d", i, act_o[i], act_n[i], q[i].exp, q[i].n);
            end
        end
        n_tests++;
        if (instret !== 64'd4) begin
            n_fail++; $display("FAIL alu_instret: got %0d want 4", instret);
        end
    endtask

    task automatic test_fetch_wait();
        q.delete();
        gen_instr(5, 0, 0, 0, 0, 0, 0, 0);
        play();
        foreach (q[i]) begin
            n_tests++;
            if (act_o[i] !== q[i].exp || act_n[i] !== q[i].n) begin
                n_fail++;
                $display("FAIL fetch_wait[%0d]: got %b/%0d want %b/%0d", i, act_o[i], act_n[i], q[i].exp, q[i].n);
            end
        end
    endtask

    task automatic test_mem();
        q.delete();
        gen_instr(0, 1, 0, 3, 0, 0, 0, 0);
        gen_instr(0, 1, 0, 1, 1, 0, 0, 0);
        gen_instr(1, 1, 0, 0, 0, 0, 0, 0);
        play();
        foreach (q[i]) begin
            n_tests++;
            if (act_o[i] !== q[i].exp || act_n[i] !== q[i].n) begin
                n_fail++;
                $display("FAIL mem[%0d]: got %b/%0d want %b/%0d", i, act_o[i], act_n[i], q[i].exp, q[i].n);
            end
        end
    endtask

    task automatic test_trap_priority();
        q.delete();
        gen_instr(0, 1, 1, 0, 0, 0, 0, 0);
        gen_instr(0, 0, 1, 0, 0, 0, 0, 0);
        play();
        foreach (q[i]) begin
            n_tests++;
            if (act_o[i] !== q[i].exp || act_n[i] !== q[i].n) begin
                n_fail++;
                $display("FAIL trap_prio[%0d]: got %b/%0d want %b/%0d", i, act_o[i], act_n[i], q[i].exp, q[i].n);
            end
        end
    endtask

    task automatic test_irq_halt();
        q.delete();
        gen_instr(0, 0, 0, 0, 0, 1, 1, 2);
        gen_instr(0, 0, 0, 0, 0, 0, 1, 0);
        gen_instr(0, 0, 0, 0, 0, 1, 0, 0);
        play();
        foreach (q[i]) begin
            n_tests++;
            if (act_o[i] !== q[i].exp || act_n[i] !== q[i].n) begin
                n_fail++;
                $display("FAIL irq_halt[%0d]: got %b/%0d want %b/%0d", i, act_o[i], act_n[i], q[i].exp, q[i].n);
            end
        end
    endtask

    task automatic test_random();
        q.delete();
        for (int unsigned k = 0; k < 30; k++) begin
            gen_instr($urandom_range(0, 3), ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0),
                      $urandom_range(0, 3), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
        end
        play();
        foreach (q[i]) begin
            n_tests++;
            if (act_o[i] !== q[i].exp || act_n[i] !== q[i].n || act_n3[i] !== 3'(q[i].n)) begin
                n_fail++;
                $display("FAIL random[%0d]: got %b/%0d/%0d want %b/%0d/%0d", i, act_o[i], act_n[i],
                         act_n3[i], q[i].exp, q[i].n, 3'(q[i].n));
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        fetch_stage_ready = 1; exec_is_mem = 0; exec_trap = 0; mem_stage_ready = 0;
        irq_pending = 0; halt_req = 0;
        @(negedge clk);
        n_tests++;
        if (outs() !== O_E) begin
            n_fail++; $display("FAIL rstmem_exec: got %b want %b", outs(), O_E);
        end
        fetch_stage_ready = 0; exec_is_mem = 1;
        @(negedge clk);
        exec_is_mem = 0;
        @(negedge clk);
        n_tests++;
        if (outs() !== O_M || instret !== 64'(model_cnt)) begin
            n_fail++; $display("FAIL rstmem_wait: got %b/%0d want %b/%0d", outs(), instret, O_M, model_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (outs() !== O_NONE || instret !== 64'd0 || instret_n !== 3'd0) begin
            n_fail++; $display("FAIL rstmem_clear: got %b/%0d/%0d want %b/0/0", outs(), instret, instret_n, O_NONE);
        end
        rst = 1'b0;
        model_cnt = 0;
        @(negedge clk);
        n_tests++;
        if (outs() !== O_F) begin
            n_fail++; $display("FAIL rstmem_refetch: got %b want %b", outs(), O_F);
        end
    endtask

    initial begin
        test_reset();
        test_alu_stream();
        test_fetch_wait();
        test_mem();
        test_trap_priority();
        test_irq_halt();
        test_random();
        test_reset_mid_mem();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/core_stage_ctrl.md
# core_stage_ctrl

Multi-cycle stage sequencer for the core. It issues one valid/ready transaction per stage in order: FETCH, EXEC, optional MEM, then WB. It steers the trap path and the PC commit, and counts retired instructions. It sits directly upstream of the fetch stage and drives its `fetch_stage_valid`. It drives the exec, memory and write-back stages the same way.

## Interface
Parameters:
- `INSTRET_W`, default 64: width of the retired-instruction counter.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_stage_valid`  out  1  request to the fetch stage.
- `fetch_stage_ready`  in  1  fetch completed this cycle.
- `exec_stage_valid`  out  1  one-cycle execute strobe.
- `exec_is_mem`  in  1  the current instruction is a load or store (sampled in EXEC).
- `exec_trap`  in  1  illegal, ecall or ebreak detected (sampled in EXEC).
- `mem_stage_valid`  out  1  request to the memory stage.
- `mem_stage_ready`  in  1  memory access finished.
- `mem_fault`  in  1  access fault (qualified by `mem_stage_ready`).
- `wb_stage_valid`  out  1  register-file write enable strobe.
- `pc_commit`  out  1  the fetch stage loads its new PC (drives `pc_new_valid`).
- `trap_valid`  out  1  one-cycle strobe to the CSR/trap unit.
- `irq_pending`  in  1  enabled interrupt pending (already masked by CSRs).
- `halt_req`  in  1  debug halt request.
- `halted`  out  1  the core is parked in HALT.
- `instret`  out  `INSTRET_W`  count of retired instructions.

## Operation
- States: IDLE, FETCH, EXEC, MEM, WB, TRAP, HALT. All outputs except `instret` are decoded from the state register (Moore).
- IDLE: all strobes low. Goes to FETCH on the next cycle.
- FETCH:
  - `fetch_stage_valid`=1 and stays high until `fetch_stage_ready`; it never drops before the handshake.
  - On handshake, go to EXEC.
  - If `halt_req`=1 on entry into FETCH (the cycle the next state is computed as FETCH), go to HALT instead. A halt is never taken mid-handshake.
- EXEC:
  - `exec_stage_valid`=1 for exactly one cycle.
  - Next state: TRAP if `exec_trap`; else MEM if `exec_is_mem`; else WB.
  - `exec_trap` has priority over `exec_is_mem`.
- MEM: `mem_stage_valid`=1 until `mem_stage_ready`. Then TRAP if `mem_fault`, else WB. Stores also pass through WB; the exec side masks the register write.
- WB:
  - `wb_stage_valid`=1 and `pc_commit`=1 for one cycle.
  - `instret` increments by 1.
  - Next state is TRAP if `irq_pending`, else FETCH, or HALT if `halt_req`. Priority: irq > halt > fetch.
- TRAP:
  - `trap_valid`=1 and `pc_commit`=1 for one cycle. The trap unit supplies the trap vector as `pc_new`.
  - No `instret` increment. Next state is FETCH.
- HALT: `halted`=1 and all strobes low. Leave to FETCH on the first cycle `halt_req`=0.
- `instret` wraps modulo 2^`INSTRET_W` with no saturation.

## Timing
- Reset values: state=IDLE and `instret`=0. With state=IDLE every output is 0.
- Reset is synchronous: in the cycle `rst` is first sampled, outputs still reflect the previous state. From the next edge they are all 0. This holds for any state, including in the middle of a FETCH or MEM handshake.
- The first `fetch_stage_valid` appears 1 cycle after reset is released (IDLE, then FETCH).
- ALU instruction with zero-wait fetch: FETCH, EXEC, WB = 3 cycles; back-to-back throughput is one instruction per 3 cycles.
- A load or store with zero-wait memory takes 4 cycles; each ready wait-cycle adds 1.
- `pc_commit` occurs in WB/TRAP, never in FETCH, so it cannot collide with `fetch_done`.
- `instret` updates at the edge that ends WB. It is visible the cycle after WB.

## Structure
- `core_pkg` holds:
  - `ctrl_state_e`, a 3-bit enum for the seven states.
  - the `INSTRET_W` default constant, shared with the CSR file.
- Sub-module `core_ctrl_counter`: a `INSTRET_W`-wide counter with `inc` and synchronous `rst`. It is reused later for `mcycle`.

## Test plan
- Reset release with ready tied high, ALU-only instructions → `fetch_stage_valid` at cycle 1. Strobes follow the pattern fetch/exec/wb every 3 cycles. `instret`=4 after 12 cycles.
- `fetch_stage_ready` held low for 5 cycles → `fetch_stage_valid` stays high for all 6 cycles and EXEC starts on the 7th.
- `exec_is_mem`=1 and `mem_stage_ready` delayed 3 cycles → the instruction takes 7 cycles and `instret` is +1. With `mem_fault`=1: TRAP, `trap_valid` pulse, `instret` unchanged.
- `exec_trap`=1 together with `exec_is_mem`=1 → go to TRAP, no `mem_stage_valid`, then `pc_commit` and FETCH.
- `irq_pending` and `halt_req` both high in WB → TRAP first, then HALT on the next FETCH entry. Dropping `halt_req` gives FETCH on the following cycle.
- `rst` asserted in the middle of a MEM wait, and `instret` preset to 2^64-1 and then retiring one instruction → all outputs 0 one cycle after reset is sampled. The counter wraps to 0.
